// File: rtl/cnn_result_reader_pkg.sv
// Shared definitions for the CNN result-buffer drain: FSM encoding and default widths.
package cnn_result_reader_pkg;

    localparam int unsigned DEFAULT_RESULT_BUFFER_WIDTH = 16;
    localparam int unsigned DEFAULT_COUNT_WIDTH         = 7;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StGap   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/cnn_result_beat_fifo.sv
// First-word-fall-through FIFO holding packed output beats {last, keep, data}.
module cnn_result_beat_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_result_reader.sv
// Drains a programmed number of words from the CNN result buffer and packs them
// PACK-per-beat into a valid/ready output stream.
module cnn_result_reader
    import cnn_result_reader_pkg::*;
#(
    parameter int unsigned RESULT_BUFFER_WIDTH = DEFAULT_RESULT_BUFFER_WIDTH,
    parameter int unsigned PACK                = 4,
    parameter int unsigned COUNT_WIDTH         = DEFAULT_COUNT_WIDTH,
    parameter int unsigned OUT_FIFO_DEPTH      = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [COUNT_WIDTH-1:0]              read_count,
    output logic                                busy,
    output logic                                done,
    output logic [COUNT_WIDTH-1:0]              words_read,
    input  logic [RESULT_BUFFER_WIDTH-1:0]      result_buffer_out,
    input  logic                                result_buffer_empty,
    input  logic                                result_buffer_valid,
    output logic                                result_buffer_read_enable,
    output logic [RESULT_BUFFER_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]                     out_keep,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready
);
    localparam int unsigned LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned BEAT_W  = RESULT_BUFFER_WIDTH * PACK;
    localparam int unsigned ENTRY_W = 1 + PACK + BEAT_W;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_words_read;
    logic [LANE_W-1:0]      r_lane;
    logic [BEAT_W-1:0]      r_pack;
    logic                   r_rd_hold;
    logic                   r_empty;

    logic                   w_start_acc;
    logic                   w_rd_en;
    logic                   w_capture;
    logic                   w_last_word;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [BEAT_W-1:0]      w_beat_data;
    logic [PACK-1:0]        w_beat_keep;
    logic [ENTRY_W-1:0]     w_push_entry;
    logic [ENTRY_W-1:0]     w_head_entry;

    // Buffer empty is registered so the request decision never depends combinationally on it;
    // the GAP cycle gives the flag time to reflect the previous pop.
    assign w_rd_en     = (r_state == StReq) && (r_rd_hold || (!r_empty && !w_fifo_full));
    assign w_capture   = w_rd_en && result_buffer_valid;
    assign w_last_word = ((r_words_read + COUNT_WIDTH'(1)) == r_count);
    assign w_push      = w_capture && ((r_lane == LANE_W'(PACK - 1)) || w_last_word);
    assign w_pop       = out_valid && out_ready;

    always_comb begin
        w_beat_data = r_pack;
        w_beat_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (LANE_W'(i) == r_lane) begin
                w_beat_data[i*RESULT_BUFFER_WIDTH +: RESULT_BUFFER_WIDTH] = result_buffer_out;
            end
            if (LANE_W'(i) <= r_lane) begin
                w_beat_keep[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = (read_count == '0) ? StDone : StReq;
                end
            end
            StReq:   if (w_capture) w_state_next = StGap;
            StGap:   w_state_next = (r_words_read == r_count) ? StDrain : StReq;
            StDrain: if (w_fifo_empty) w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_words_read <= '0;
            r_lane       <= '0;
            r_pack       <= '0;
            r_rd_hold    <= 1'b0;
            r_empty      <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_empty <= result_buffer_empty;
            if (w_start_acc) begin
                r_count      <= read_count;
                r_words_read <= '0;
                r_lane       <= '0;
                r_pack       <= '0;
                r_rd_hold    <= 1'b0;
            end else if (r_state == StReq) begin
                if (w_capture) begin
                    r_words_read <= r_words_read + COUNT_WIDTH'(1);
                    r_lane       <= w_push ? '0 : r_lane + LANE_W'(1);
                    r_pack       <= w_push ? '0 : w_beat_data;
                    r_rd_hold    <= 1'b0;
                end else begin
                    r_rd_hold <= w_rd_en;
                end
            end
        end
    end

    assign w_push_entry = {w_last_word, w_beat_keep, w_beat_data};

    cnn_result_beat_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_beat_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_entry),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign {out_last, out_keep, out_data} = w_head_entry;
    assign out_valid                      = !w_fifo_empty;
    assign result_buffer_read_enable      = w_rd_en;
    assign busy       = (r_state == StReq) || (r_state == StGap) || (r_state == StDrain);
    assign done       = (r_state == StDone);
    assign words_read = r_words_read;

endmodule

// File: tb/tb_cnn_result_reader.sv
// Directed-sequence bench with a randomized result-buffer model and a word-chunking beat model.
module tb_cnn_result_reader;
    localparam int RBW  = 16;
    localparam int PACK = 4;
    localparam int CW   = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     read_count = '0;
    logic              busy, done;
    logic [CW-1:0]     words_read;
    logic [RBW-1:0]    result_buffer_out;
    logic              result_buffer_empty;
    logic              result_buffer_valid;
    logic              result_buffer_read_enable;
    logic [RBW*PACK-1:0] out_data;
    logic [PACK-1:0]   out_keep;
    logic              out_last, out_valid;
    logic              out_ready = 1'b1;

    cnn_result_reader #(
        .RESULT_BUFFER_WIDTH (RBW),
        .PACK                (PACK),
        .COUNT_WIDTH         (CW),
        .OUT_FIFO_DEPTH      (2)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .read_count                (read_count),
        .busy                      (busy),
        .done                      (done),
        .words_read                (words_read),
        .result_buffer_out         (result_buffer_out),
        .result_buffer_empty       (result_buffer_empty),
        .result_buffer_valid       (result_buffer_valid),
        .result_buffer_read_enable (result_buffer_read_enable),
        .out_data                  (out_data),
        .out_keep                  (out_keep),
        .out_last                  (out_last),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Words offered by the buffer; the main sequence appends, the buffer process consumes.
    logic [RBW-1:0] arr [0:255];
    int buf_n       = 0;
    int valid_lat   = 0;
    bit force_empty = 1'b0;
    bit spurious    = 1'b0;
    int rd_idx      = 0;
    int en_cnt      = 0;

    initial begin
        result_buffer_valid = 1'b0;
        result_buffer_out   = '0;
        result_buffer_empty = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            result_buffer_valid = 1'b0;
            result_buffer_empty = force_empty || (rd_idx >= buf_n);
            #1;
            if (result_buffer_read_enable) begin
                en_cnt++;
                if (en_cnt > valid_lat && rd_idx < buf_n) begin
                    result_buffer_out   = arr[rd_idx];
                    result_buffer_valid = 1'b1;
                    rd_idx++;
                    en_cnt = 0;
                end
            end else begin
                en_cnt = 0;
                if (spurious) begin
                    result_buffer_out   = 16'hdead;
                    result_buffer_valid = 1'b1;
                end
            end
        end
    end

    // Observation of the read port and accepted beats.
    int             en_cycles = 0;
    int             en_rises  = 0;
    int             gap_viol  = 0;
    bit             prev_en   = 1'b0;
    bit             prev_cap  = 1'b0;
    int             got_n     = 0;
    logic [63:0]    got_data [0:127];
    logic [PACK-1:0] got_keep [0:127];
    logic           got_last [0:127];

    always @(negedge clk) begin
        if (reset) begin
            if (result_buffer_read_enable) en_cycles <= en_cycles + 1;
            if (result_buffer_read_enable && !prev_en) en_rises <= en_rises + 1;
            if (result_buffer_read_enable && prev_cap) gap_viol <= gap_viol + 1;
            prev_cap <= result_buffer_read_enable && result_buffer_valid;
            prev_en  <= result_buffer_read_enable;
            if (out_valid && out_ready && got_n < 128) begin
                got_data[got_n] <= out_data;
                got_keep[got_n] <= out_keep;
                got_last[got_n] <= out_last;
                got_n           <= got_n + 1;
            end
        end else begin
            prev_en  <= 1'b0;
            prev_cap <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            arr[buf_n] = 16'($urandom);
            buf_n++;
        end
    endtask

    task automatic start_cmd(input int n);
        @(posedge clk);
        #1;
        read_count = n[CW-1:0];
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_in_time"}, done, 1'b1);
        cyc(1);
    endtask

    // Expected beats: consecutive chunks of PACK words, lane 0 first, last on the final chunk.
    task automatic check_beats(input string tag, input int s, input int n, input int base);
        int nb;
        logic [63:0] d;
        logic [PACK-1:0] k;
        nb = (n + PACK - 1) / PACK;
        check({tag, "_nbeats"}, 64'(got_n - base), 64'(nb));
        for (int b = 0; b < nb && base + b < 128; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < PACK; j++) begin
                if (b * PACK + j < n) begin
                    d[j*RBW +: RBW] = arr[s + b*PACK + j];
                    k[j] = 1'b1;
                end
            end
            check({tag, "_data"}, got_data[base + b], d);
            check({tag, "_keep"}, 64'(got_keep[base + b]), 64'(k));
            check({tag, "_last"}, 64'(got_last[base + b]), 64'(b == nb - 1));
        end
    endtask

    int exp_idx = 0;
    int b_en, b_rise, b_got, s;

    initial begin
        // Reset state
        cyc(3);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rden", result_buffer_read_enable, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_words_read", 64'(words_read), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(2);

        // 1: eight random words, valid one cycle after enable
        valid_lat = 1;
        add_random(8);
        b_en = en_cycles; b_rise = en_rises; b_got = got_n; s = exp_idx;
        start_cmd(8);
        wait_done("t1", 300);
        check("t1_en_pulses", 64'(en_rises - b_rise), 64'd8);
        check("t1_en_cycles", 64'(en_cycles - b_en), 64'd16);
        check("t1_words_read", 64'(words_read), 64'd8);
        check("t1_busy", busy, 1'b0);
        check_beats("t1", s, 8, b_got);
        exp_idx += 8;

        // 2: words 1..5, first enable one cycle after start, 2 cycles per word
        valid_lat = 0;
        for (int i = 1; i <= 5; i++) begin
            arr[buf_n] = 16'(i);
            buf_n++;
        end
        b_en = en_cycles; b_got = got_n; s = exp_idx;
        start_cmd(5);
        @(negedge clk);
        check("t2_rden_latency", result_buffer_read_enable, 1'b1);
        check("t2_busy", busy, 1'b1);
        check("t2_done_cleared", done, 1'b0);
        wait_done("t2", 300);
        check("t2_en_cycles", 64'(en_cycles - b_en), 64'd5);
        check("t2_words_read", 64'(words_read), 64'd5);
        check_beats("t2", s, 5, b_got);
        exp_idx += 5;

        // 3: buffer held empty, stray valid pulses, then valid four cycles after enable
        force_empty = 1'b1;
        spurious    = 1'b1;
        valid_lat   = 4;
        add_random(6);
        b_en = en_cycles; b_rise = en_rises; b_got = got_n; s = exp_idx;
        start_cmd(6);
        cyc(20);
        check("t3_no_rden_while_empty", 64'(en_cycles - b_en), 64'd0);
        check("t3_stray_valid_ignored", 64'(words_read), 64'd0);
        check("t3_busy_waiting", busy, 1'b1);
        spurious    = 1'b0;
        force_empty = 1'b0;
        @(negedge clk);
        check("t3_rden_not_yet", result_buffer_read_enable, 1'b0);
        @(negedge clk);
        check("t3_rden_after_empty_falls", result_buffer_read_enable, 1'b1);
        wait_done("t3", 400);
        check("t3_en_pulses", 64'(en_rises - b_rise), 64'd6);
        check("t3_en_cycles", 64'(en_cycles - b_en), 64'd30);
        check_beats("t3", s, 6, b_got);
        exp_idx += 6;

        // 4: downstream stalled with 16 words requested
        valid_lat = 0;
        out_ready = 1'b0;
        add_random(16);
        b_en = en_cycles; b_got = got_n; s = exp_idx;
        start_cmd(16);
        cyc(60);
        check("t4_words_at_stall", 64'(words_read), 64'd8);
        check("t4_en_cycles_at_stall", 64'(en_cycles - b_en), 64'd8);
        check("t4_no_beats_taken", 64'(got_n - b_got), 64'd0);
        check("t4_rden_stopped", result_buffer_read_enable, 1'b0);
        check("t4_out_valid_held", out_valid, 1'b1);
        check("t4_busy", busy, 1'b1);
        out_ready = 1'b1;
        wait_done("t4", 400);
        check("t4_words_read", 64'(words_read), 64'd16);
        check_beats("t4", s, 16, b_got);
        exp_idx += 16;

        // 5: zero-length command, then a start pulse while busy
        b_en = en_cycles; b_got = got_n;
        start_cmd(0);
        @(negedge clk);
        check("t5_zero_done", done, 1'b1);
        check("t5_zero_busy", busy, 1'b0);
        cyc(5);
        check("t5_zero_no_rden", 64'(en_cycles - b_en), 64'd0);
        check("t5_zero_no_beats", 64'(got_n - b_got), 64'd0);
        check("t5_zero_words", 64'(words_read), 64'd0);
        valid_lat = 3;
        add_random(4);
        b_got = got_n; s = exp_idx;
        start_cmd(4);
        cyc(2);
        check("t5_busy_before_restart", busy, 1'b1);
        start_cmd(9);
        wait_done("t5", 300);
        check("t5_words_unchanged", 64'(words_read), 64'd4);
        check_beats("t5", s, 4, b_got);
        exp_idx += 4;

        // 6: reset while read_enable is held, then a clean 3-word command
        valid_lat = 100;
        add_random(6);
        start_cmd(6);
        cyc(3);
        @(negedge clk);
        check("t6_rden_before_reset", result_buffer_read_enable, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rden_async", result_buffer_read_enable, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        check("t6_out_valid_async", out_valid, 1'b0);
        check("t6_words_async", 64'(words_read), 64'd0);
        valid_lat = 0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        b_got = got_n; s = exp_idx;
        start_cmd(3);
        wait_done("t6", 300);
        check("t6_words_read", 64'(words_read), 64'd3);
        check_beats("t6", s, 3, b_got);
        exp_idx += 3;

        check("gap_after_every_capture", 64'(gap_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cnn_result_reader.md
Name: cnn_result_reader

Overview:
Hardware drain for the CNN result buffer read port. After a start command it pops a programmed number of result words using the buffer's read_enable/valid/empty handshake. It packs PACK words per beat into a wide output stream with valid/ready flow control. It sits between the CNN result buffer and the downstream writeback/host path, and replaces the manual read loop used in bring-up.

Parameters:
RESULT_BUFFER_WIDTH, 16, width of one result word
PACK, 4, result words per output beat (1..8)
COUNT_WIDTH, 7, width of read_count and words_read (up to 127 words)
OUT_FIFO_DEPTH, 2, output beat FIFO depth (power of two)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle command pulse; ignored unless idle or done
read_count  in  COUNT_WIDTH  number of words to drain; sampled on accepted start
busy  out  1  high from accepted start until the last beat is accepted downstream
done  out  1  level, high in DONE state
words_read  out  COUNT_WIDTH  words popped since the last accepted start
result_buffer_out  in  RESULT_BUFFER_WIDTH  result word from the buffer
result_buffer_empty  in  1  buffer has no words
result_buffer_valid  in  1  result_buffer_out holds the word for the current read
result_buffer_read_enable  out  1  read request, level-held until valid
out_data  out  RESULT_BUFFER_WIDTH*PACK  packed beat; lane 0 = first word, LSBs
out_keep  out  PACK  per-lane valid mask
out_last  out  1  final beat of the command
out_valid  out  1  beat available
out_ready  in  1  downstream accepts when out_valid&&out_ready

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE. read_enable, busy, done, out_valid, out_last, and words_read are 0. out_keep and the pack register are cleared. The FIFO is emptied.
- FSM states: IDLE, REQ, GAP, DRAIN, DONE.
- IDLE/DONE with start=1:
  - Latch read_count.
  - Clear words_read, lane index, pack register.
  - done goes to 0 and busy goes to 1 in the next cycle.
  - If read_count==0, go straight to DONE with no beat emitted.
  - Otherwise go to REQ.
- REQ:
  - Assert read_enable when result_buffer_empty==0 and the FIFO has a free slot (counting a beat about to be pushed).
  - Once asserted, read_enable stays high until a cycle with result_buffer_valid=1, regardless of later empty changes.
  - On read_enable&&valid: capture the word into the current lane, increment words_read and the lane index, go to GAP.
- Valid arriving while read_enable=0 is ignored.
- GAP: read_enable is low for exactly 1 cycle. Then:
  - DRAIN if words_read==read_count;
  - otherwise REQ.
- Beat push: occurs in the capture cycle when the lane index reaches PACK-1 or the captured word is the last word.
  - Unused lanes are zero and out_keep has ones only for filled lanes.
  - out_last=1 on the final beat.
  - The lane index then resets to 0.
- FIFO: OUT_FIFO_DEPTH entries with first-word fall-through.
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - A push is never issued when the FIFO is full (REQ back-pressure guarantees this).
- DRAIN: wait until the FIFO is empty (last beat accepted), then go to DONE. busy falls in the same cycle done rises.
- start during REQ, GAP or DRAIN is ignored.
- Latency: the first read_enable rises 1 cycle after start (if not empty). The captured word appears on out_valid 1 cycle after the capture cycle.
- Throughput: at most 1 word per 2 cycles when valid returns in the first enable cycle.
- Reset mid-command abandons all state, and read_enable drops immediately.

Decomposition:
- Shared package holds:
  - FSM state encoding constants;
  - default widths (RESULT_BUFFER_WIDTH=16, COUNT_WIDTH=7).
- One sub-module is natural: cnn_result_beat_fifo, a parameterized first-word-fall-through FIFO carrying {out_last, out_keep, out_data}.

Test Plan:
1. PACK=4, read_count=8, buffer never empty, valid 1 cycle after enable, out_ready=1.
   -> 8 enable pulses with 1-cycle gaps, then 2 beats, both with out_keep=4'b1111. The second beat has out_last=1. words_read=8, then done=1.
2. read_count=5, words 0x0001..0x0005.
   -> Beat 1 has lanes 1..4 and out_keep=1111. Beat 2 has data 0x0005 in lane 0 with zeros above, out_keep=4'b0001 and out_last=1.
3. empty=1 for 20 cycles after start.
   -> read_enable stays 0. It rises 1 cycle after empty falls. With valid delayed 4 cycles, read_enable stays high for 5 cycles.
4. out_ready=0 with read_count=16.
   -> The FIFO fills with 2 beats, then read_enable stops after 8 words with words_read=8. Releasing out_ready resumes the drain, and all 4 beats arrive in order.
5. start with read_count=0, plus a second start pulse while busy.
   -> The first gives done=1 with no beats and no read_enable. The second start is ignored and words_read is unchanged.
6. Assert reset while read_enable is high mid-command.
   -> read_enable, busy, and out_valid go to 0 asynchronously. A fresh start with read_count=3 drains cleanly: 1 beat with out_keep=0111 and out_last=1.
